// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
// Transmit stage behind the UART byte FIFO. It pops one byte at a time and
// shifts it out LSB-first as one frame: start bit, 8 data bits, optional
// parity bit, then 1 or 2 stop bits. The bit period is baud_div + 1 clocks.
//
// Ports
//   clk              system clock, rising edge
//   rst              asynchronous reset, active low
//   enable           allows new frames to start; a frame in flight always completes
//   baud_div         bit period minus one, latched in LOAD
//   parity_en        append a parity bit, latched in LOAD
//   parity_odd       1 = odd parity, 0 = even parity, latched in LOAD
//   two_stop         1 = two stop bits, latched in LOAD
//   fifo_empty       FIFO empty flag, examined only in IDLE
//   fifo_read_data   FIFO head byte
//   fifo_read_strobe single-cycle pop request
//   tx               serial line, idles high
//   busy             high in every state except IDLE
//   frame_done       one-cycle pulse in the last clock of the last stop bit
//   frame_count      completed frames, wraps modulo 2^32
//
// FIFO handshake: the FIFO presents its head byte with fifo_empty low; the
// block issues exactly one fifo_read_strobe cycle (LOAD) per frame, takes
// fifo_read_data during that same cycle, and the FIFO advances after it.
// There is no back-pressure: a strobe is only issued when fifo_empty was low.
//
// All outputs are registers loaded from the next-state values, so each
// output reflects the state the block is in during that same cycle.

module uart_tx_serializer #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  input  logic                 fifo_empty,
  input  logic [7:0]           fifo_read_data,
  output logic                 fifo_read_strobe,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done,
  output logic [31:0]          frame_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_t;

  localparam logic [DIV_WIDTH-1:0] CNT_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  state_t               state, state_n;
  logic [DIV_WIDTH-1:0] cnt, cnt_n;
  logic [DIV_WIDTH-1:0] div_q, div_n;
  logic [2:0]           bit_idx, bit_n;
  logic                 stop_idx, stop_n;
  logic [7:0]           shreg, sh_n;
  logic                 par_en_q, pen_n;
  logic                 two_stop_q, two_n;
  logic                 par_bit, par_n;
  logic                 tx_n;
  logic                 done_n;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    div_n   = div_q;
    bit_n   = bit_idx;
    stop_n  = stop_idx;
    sh_n    = shreg;
    pen_n   = par_en_q;
    two_n   = two_stop_q;
    par_n   = par_bit;

    case (state)
      IDLE: begin
        if (enable && !fifo_empty) state_n = LOAD;
      end
      LOAD: begin
        sh_n    = fifo_read_data;
        div_n   = baud_div;
        pen_n   = parity_en;
        two_n   = two_stop;
        par_n   = (^fifo_read_data) ^ parity_odd;
        cnt_n   = baud_div;
        bit_n   = 3'd0;
        stop_n  = 1'b0;
        state_n = START;
      end
      START: begin
        if (cnt == '0) begin
          cnt_n   = div_q;
          state_n = DATA;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      DATA: begin
        if (cnt == '0) begin
          cnt_n = div_q;
          if (bit_idx == 3'd7) begin
            state_n = par_en_q ? PARITY : STOP;
          end else begin
            bit_n = bit_idx + 3'd1;
            // The line always shows sh_n[0], so shift on every bit advance.
            sh_n  = {1'b0, shreg[7:1]};
          end
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      PARITY: begin
        if (cnt == '0) begin
          cnt_n   = div_q;
          state_n = STOP;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      STOP: begin
        if (cnt == '0) begin
          if (two_stop_q && !stop_idx) begin
            stop_n = 1'b1;
            cnt_n  = div_q;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      default: state_n = IDLE;
    endcase

    tx_n = 1'b1;
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = sh_n[0];
      PARITY:  tx_n = par_n;
      default: tx_n = 1'b1;
    endcase

    // Next cycle is the final clock of the final stop bit.
    done_n = (state_n == STOP) && (cnt_n == '0) && (!two_n || stop_n);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      cnt              <= '0;
      div_q            <= '0;
      bit_idx          <= 3'd0;
      stop_idx         <= 1'b0;
      shreg            <= 8'd0;
      par_en_q         <= 1'b0;
      two_stop_q       <= 1'b0;
      par_bit          <= 1'b0;
      tx               <= 1'b1;
      fifo_read_strobe <= 1'b0;
      busy             <= 1'b0;
      frame_done       <= 1'b0;
      frame_count      <= 32'd0;
    end else begin
      state            <= state_n;
      cnt              <= cnt_n;
      div_q            <= div_n;
      bit_idx          <= bit_n;
      stop_idx         <= stop_n;
      shreg            <= sh_n;
      par_en_q         <= pen_n;
      two_stop_q       <= two_n;
      par_bit          <= par_n;
      tx               <= tx_n;
      fifo_read_strobe <= (state_n == LOAD);
      busy             <= (state_n != IDLE);
      frame_done       <= done_n;
      if (done_n) frame_count <= frame_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          enable = 1'b0;
  logic [W-1:0]  baud_div = '0;
  logic          parity_en = 1'b0;
  logic          parity_odd = 1'b0;
  logic          two_stop = 1'b0;
  logic          fifo_empty;
  logic [7:0]    fifo_read_data;
  logic          fifo_read_strobe;
  logic          tx;
  logic          busy;
  logic          frame_done;
  logic [31:0]   frame_count;

  uart_tx_serializer #(.DIV_WIDTH(W)) dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .baud_div         (baud_div),
    .parity_en        (parity_en),
    .parity_odd       (parity_odd),
    .two_stop         (two_stop),
    .fifo_empty       (fifo_empty),
    .fifo_read_data   (fifo_read_data),
    .fifo_read_strobe (fifo_read_strobe),
    .tx               (tx),
    .busy             (busy),
    .frame_done       (frame_done),
    .frame_count      (frame_count)
  );

  // ---------------- FIFO stand-in ----------------
  logic [7:0] fifo_mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty     = (wr_ptr == rd_ptr);
  assign fifo_read_data = fifo_mem[rd_ptr[3:0]];
  always @(posedge clk) if (rst && fifo_read_strobe) rd_ptr <= rd_ptr + 1;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected line, one entry per clock: {frame_done, tx}.
  logic [1:0] exp_q[$];
  logic [1:0] e;
  int         m_count = 0;
  logic       m_idle = 1'b1;
  logic       pending = 1'b0;
  logic [7:0] pend_byte = 8'd0;

  // Build a whole frame from the line rules using the configuration the
  // DUT latches at the end of LOAD (visible at this sample).
  task automatic build_frame(input logic [7:0] b);
    logic levels[$];
    int   per;
    levels.push_back(1'b0);
    for (int i = 0; i < 8; i++) levels.push_back(b[i]);
    if (parity_en) levels.push_back((^b) ^ parity_odd);
    levels.push_back(1'b1);
    if (two_stop) levels.push_back(1'b1);
    per = int'(baud_div) + 1;
    for (int k = 0; k < levels.size(); k++)
      for (int j = 0; j < per; j++)
        exp_q.push_back({(k == levels.size() - 1) && (j == per - 1), levels[k]});
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      exp_q.delete();
      pending = 1'b0;
      m_idle  = 1'b1;
      m_count = 0;
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_strobe", fifo_read_strobe, 0);
      check("rst_done", frame_done, 0);
      check("rst_count", frame_count, 0);
    end else begin
      if (pending) begin
        build_frame(pend_byte);
        pending = 1'b0;
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("line_tx", tx, e[0]);
        check("line_done", frame_done, e[1]);
        check("line_busy", busy, 1);
        check("line_strobe", fifo_read_strobe, 0);
        if (e[1]) m_count++;
        m_idle = 1'b0;
      end else if (m_idle && enable && !fifo_empty) begin
        check("load_strobe", fifo_read_strobe, 1);
        check("load_busy", busy, 1);
        check("load_tx", tx, 1);
        check("load_done", frame_done, 0);
        pending   = 1'b1;
        pend_byte = fifo_read_data;
        m_idle    = 1'b0;
      end else begin
        check("idle_strobe", fifo_read_strobe, 0);
        check("idle_busy", busy, 0);
        check("idle_tx", tx, 1);
        check("idle_done", frame_done, 0);
        check("idle_count", frame_count, m_count[31:0]);
        m_idle = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic line_rec [0:255];

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr[3:0]] = b;
    wr_ptr++;
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_strobe(input int max, output int waited);
    waited = 0;
    forever begin
      @(posedge clk); #1;
      waited++;
      if (fifo_read_strobe === 1'b1 || waited >= max) break;
    end
    check("strobe_seen", fifo_read_strobe, 1);
  endtask

  // Records tx per clock from the call on; returns the clock index of frame_done.
  task automatic record_frame(input int max, output int done_at);
    done_at = 0;
    for (int i = 1; i <= max; i++) begin
      @(posedge clk); #1;
      line_rec[i] = tx;
      if (frame_done === 1'b1) begin
        done_at = i;
        break;
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int w;
    int d;
    int strobes;
    logic [9:0] a5_line;
    a5_line = 10'b1101001010;  // bit k = line level of bit period k
    for (int i = 0; i < 16; i++) fifo_mem[i] = 8'h00;

    // Reset: 3 clocks low, then 100 idle clocks with an empty FIFO.
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("reset_count", frame_count, 0);
    check("reset_tx", tx, 1);

    // Async reset mid-frame at data bit 4 (0x2C has bit 4 = 0).
    @(negedge clk);
    baud_div = 16'd3;
    push(8'h2C);
    push(8'hC3);
    enable = 1'b1;
    wait_strobe(10, w);
    repeat (23) @(negedge clk);
    #1;
    check("pre_rst_tx", tx, 0);
    rst = 1'b0;
    #1;
    check("async_tx", tx, 1);
    check("async_busy", busy, 0);
    check("async_count", frame_count, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_strobe(10, w);
    record_frame(60, d);
    check("after_rst_len", d, 40);
    @(posedge clk); #1;
    check("after_rst_count", frame_count, 1);

    // Single byte 0xA5, baud_div 3, no parity, one stop.
    do_reset();
    @(negedge clk);
    push(8'hA5);
    wait_strobe(10, w);
    record_frame(60, d);
    check("a5_done_at", d, 40);
    for (int k = 0; k < 10; k++)
      for (int j = 0; j < 4; j++)
        check("a5_line", line_rec[1 + 4 * k + j], a5_line[k]);
    @(posedge clk); #1;
    check("a5_count", frame_count, 1);

    // Parity on 0x07 at baud_div 0: even parity bit 1, odd parity bit 0.
    @(negedge clk);
    baud_div = 16'd0;
    parity_en = 1'b1;
    parity_odd = 1'b0;
    push(8'h07);
    wait_strobe(10, w);
    record_frame(30, d);
    check("even_len", d, 11);
    check("even_bit", line_rec[10], 1);
    @(negedge clk);
    parity_odd = 1'b1;
    push(8'h07);
    wait_strobe(10, w);
    record_frame(30, d);
    check("odd_len", d, 11);
    check("odd_bit", line_rec[10], 0);
    @(negedge clk);
    parity_odd = 1'b0;
    two_stop = 1'b1;
    push(8'h07);
    wait_strobe(10, w);
    record_frame(30, d);
    check("two_stop_len", d, 12);
    check("two_stop_s1", line_rec[11], 1);

    // Back-to-back 0x01, 0x02, 0x03 at baud_div 1.
    do_reset();
    @(negedge clk);
    baud_div = 16'd1;
    parity_en = 1'b0;
    two_stop = 1'b0;
    push(8'h01);
    push(8'h02);
    push(8'h03);
    wait_strobe(10, w);
    wait_strobe(40, w);
    check("b2b_gap1", w, 22);
    wait_strobe(40, w);
    check("b2b_gap2", w, 22);
    record_frame(30, d);
    check("b2b_len", d, 20);
    @(posedge clk); #1;
    check("b2b_count", frame_count, 3);

    // Drop enable and change baud_div during DATA.
    @(negedge clk);
    baud_div = 16'd3;
    push(8'h5A);
    push(8'h33);
    wait_strobe(10, w);
    repeat (10) @(negedge clk);
    enable = 1'b0;
    baud_div = 16'd7;
    record_frame(60, d);
    check("midcfg_done_at", d, 31);
    strobes = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (fifo_read_strobe === 1'b1) strobes++;
    end
    check("disabled_strobes", strobes, 0);
    @(negedge clk) enable = 1'b1;
    wait_strobe(5, w);
    record_frame(100, d);
    check("slow_len", d, 80);
    @(posedge clk); #1;
    check("final_count", frame_count, 5);

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Transmit stage that sits directly downstream of the UART byte FIFO inside the wishbone UART slave. It watches the FIFO's empty flag, pops one byte at a time with a single-cycle read strobe, and shifts the byte out LSB-first on the serial `tx` line. Each frame has a start bit, 8 data bits, optional parity and 1 or 2 stop bits, at a run-time programmable bit period. It also reports busy status, frame-complete pulses and a running frame count to the register file.

## Interface
Parameters:
- `DIV_WIDTH`, 16, width of the bit-period divisor input.

Ports:
- `clk`  input  1  system clock; every register is clocked on its rising edge.
- `rst`  input  1  reset, asynchronous, active-low.
- `enable`  input  1  when high, the block may start new frames; when low, a frame already in progress completes.
- `baud_div`  input  DIV_WIDTH  bit period is `baud_div + 1` clocks; sampled in LOAD.
- `parity_en`  input  1  adds a parity bit after the data bits; sampled in LOAD.
- `parity_odd`  input  1  1 = odd parity, 0 = even parity; sampled in LOAD.
- `two_stop`  input  1  1 = two stop bits, 0 = one stop bit; sampled in LOAD.
- `fifo_empty`  input  1  FIFO empty flag.
- `fifo_read_data`  input  8  FIFO head byte. Valid one clock after the FIFO read pointer last changed.
- `fifo_read_strobe`  output  1  single-cycle pop request to the FIFO.
- `tx`  output  1  serial line; idles high.
- `busy`  output  1  high in every state other than IDLE.
- `frame_done`  output  1  one-cycle pulse at the end of the last stop bit.
- `frame_count`  output  32  number of completed frames; wraps modulo 2^32.

## Operation
- All outputs are registered.
- Reset values: `tx`=1, `fifo_read_strobe`=0, `busy`=0, `frame_done`=0, `frame_count`=0. The state is IDLE and all internal counters are 0.
- **IDLE**: `tx`=1. If `enable && !fifo_empty`, go to LOAD.
- **LOAD** (exactly 1 cycle):
  - Assert `fifo_read_strobe`.
  - Latch `fifo_read_data` into the shift register. The pointer has been stable for at least 1 cycle, so the data is valid.
  - Latch `baud_div`, `parity_en`, `parity_odd` and `two_stop`.
  - Compute parity: even = XOR of the 8 data bits; odd = its inverse.
  - Load the bit-period counter with the latched divisor and go to START.
- **START**: `tx`=0 for one bit period, then go to DATA.
- **DATA**: drive data bits 0..7, LSB first, one bit period each. The 3-bit bit index counts 0..7. After bit 7, go to PARITY if `parity_en`, else STOP.
- **PARITY**: drive the parity bit for one bit period, then go to STOP.
- **STOP**: `tx`=1 for one bit period, or two if `two_stop`. At the final clock of the last stop bit, pulse `frame_done`, increment `frame_count`, and go to IDLE.
- Bit-period counter:
  - Counts down from the latched divisor to 0.
  - On 0, advance to the next bit and reload.
  - `baud_div`=0 is legal and gives 1 clock per bit.
- Configuration inputs that change mid-frame have no effect until the next LOAD.
- `enable` deasserted mid-frame: the frame completes normally, then the block stays in IDLE.
- `fifo_empty` is only examined in IDLE. It is never examined in LOAD, so at most one strobe is issued per frame and no underflow is possible.
- Reset asserted mid-frame: `tx` returns to 1 asynchronously. The popped byte is lost, and `frame_count` and `frame_done` are not updated.

## Timing
- With `!fifo_empty && enable` seen in IDLE at cycle N:
  - `fifo_read_strobe` is high during cycle N+1 (LOAD) only.
  - `tx` falls at the start of cycle N+2.
- Frame length on the line = (1 + 8 + P + S) × (`baud_div` + 1) clocks, where P ∈ {0,1} and S ∈ {1,2}.
- `frame_done` is high in the last clock of the stop period. IDLE follows on the next clock.
- Back-to-back frames have a 2-clock idle-high gap between the end of one stop bit and the next start bit (IDLE, then LOAD).
- `busy` rises in the LOAD cycle and falls on entry to IDLE.

## Test plan
- **Reset**: hold `rst`=0 for 3 clocks, then release with `fifo_empty`=1.
  - Required: `tx`=1, `busy`=0, `fifo_read_strobe`=0 and `frame_count`=0 for 100 clocks.
- **Single byte**: `baud_div`=3, no parity, 1 stop bit, FIFO holds 0xA5.
  - Required: exactly one strobe. `tx` = 0,1,0,1,0,0,1,0,1,1, each level held 4 clocks (40 clocks total). Then `frame_done` pulses and `frame_count`=1.
- **Parity and two stop bits**: byte 0x07, `parity_en`=1.
  - `parity_odd`=0: parity bit = 1.
  - `parity_odd`=1: parity bit = 0.
  - `two_stop`=1 with `baud_div`=0: required frame is 12 clocks.
- **Back-to-back**: FIFO holds 0x01, 0x02, 0x03 and `baud_div`=1.
  - Required: 3 strobes spaced 22 clocks apart, 2 idle-high clocks between frames, `frame_count`=3.
- **Enable and config change mid-frame**: during DATA, drop `enable` and change `baud_div` from 3 to 7.
  - Required: the current frame completes at 4 clocks per bit, and no further strobe occurs while `enable`=0.
- **Async reset mid-frame**: assert `rst` at data bit 4.
  - Required: `tx`=1 immediately without waiting for a clock edge, and `frame_count` unchanged. After release, the next FIFO byte is sent correctly.
